// File: rtl/stereo_pkg.sv
// Shared types and constants for the stereo disparity pipeline.
// Used by disparity_hole_fill (build option: DHF_BG_FILL_EN) and disp_nearest_valid.
package stereo_pkg;

  function automatic int disp_bits(input int range_d);
    return (range_d <= 2) ? 1 : $clog2(range_d);
  endfunction

  localparam int DISP_RANGE = 64;
  localparam int DISP_BITS  = disp_bits(DISP_RANGE);

  localparam logic [DISP_BITS-1:0] DISP_INVALID = {DISP_BITS{1'b0}};

  typedef struct packed {
    logic                 dval;
    logic [DISP_BITS-1:0] data;
    logic                 eol;
  } slot_t;

endpackage

// File: rtl/disp_nearest_valid.sv
// Combinational eol-bounded priority scan: nearest valid nonzero disparity
// ahead of the tail, never looking past the end of the tail's row.
module disp_nearest_valid
  import stereo_pkg::*;
#(
  parameter int L = 8
) (
  input  slot_t [L-1:0]         slots,
  input  logic                  tail_eol,
  output logic                  found,
  output logic [DISP_BITS-1:0]  value
);

  // Slot L-1 is nearest the tail; an eol pixel is still usable but blocks everything behind it.
  always_comb begin
    logic blocked;
    logic hit;
    found   = 1'b0;
    value   = DISP_INVALID;
    blocked = tail_eol;
    hit     = 1'b0;
    for (int k = L - 1; k >= 0; k--) begin
      hit     = !found && !blocked && slots[k].dval && (slots[k].data != DISP_INVALID);
      value   = hit ? slots[k].data : value;
      found   = found | hit;
      blocked = blocked | (slots[k].dval & slots[k].eol);
    end
  end

endmodule

// File: rtl/disparity_hole_fill.sv
// Fills disparity holes (code 0) from nearest same-row neighbours at fixed L+1 latency.
// Build option DHF_BG_FILL_EN: defined = min(left, right) fill; undefined = left-first fill.
module disparity_hole_fill
  import stereo_pkg::*;
#(
  parameter  int D    = DISP_RANGE,
  parameter  int M    = 450,
  parameter  int L    = 8,
  localparam int DBIT = disp_bits(D)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_dval,
  input  logic [DBIT-1:0] i_data,
  output logic            o_dval,
  output logic [DBIT-1:0] o_data,
  output logic            o_filled
);

  localparam int              CBIT     = (M <= 2) ? 1 : $clog2(M);
  localparam logic [CBIT-1:0] COL_LAST = CBIT'(M - 1);

  slot_t [L:0]     win;
  slot_t           head;
  slot_t           tail;
  logic [CBIT-1:0] col;
  logic [DBIT-1:0] lv;
  logic            lv_ok;
  logic            rv_found;
  logic [DBIT-1:0] rv;
  logic [DBIT-1:0] fill_data;
  logic            fill_flag;

  // Head slot; data is zeroed on idle beats so empty slots read as holes.
  always_comb begin
    head.dval = i_dval;
    head.data = i_dval ? i_data : DISP_INVALID;
    head.eol  = i_dval && (col == COL_LAST);
  end

  assign tail = win[L];

  disp_nearest_valid #(.L(L)) u_scan (
    .slots    (win[L-1:0]),
    .tail_eol (tail.eol),
    .found    (rv_found),
    .value    (rv)
  );

  // Fill mux for the pixel leaving the tail this cycle.
  always_comb begin
    fill_data = tail.data;
    fill_flag = 1'b0;
    if (i_en && tail.dval && (tail.data == DISP_INVALID)) begin
`ifdef DHF_BG_FILL_EN
      if (lv_ok && rv_found) begin
        fill_data = (lv < rv) ? lv : rv;
        fill_flag = 1'b1;
      end else if (lv_ok) begin
        fill_data = lv;
        fill_flag = 1'b1;
      end else if (rv_found) begin
        fill_data = rv;
        fill_flag = 1'b1;
      end else begin
        fill_data = DISP_INVALID;
        fill_flag = 1'b0;
      end
`else
      if (lv_ok) begin
        fill_data = lv;
        fill_flag = 1'b1;
      end else if (rv_found) begin
        fill_data = rv;
        fill_flag = 1'b1;
      end else begin
        fill_data = DISP_INVALID;
        fill_flag = 1'b0;
      end
`endif
    end else begin
      fill_data = tail.data;
      fill_flag = 1'b0;
    end
  end

  // Window shift, column count and left-candidate tracking; eol emission clears lv before any update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win   <= '0;
      col   <= '0;
      lv    <= DISP_INVALID;
      lv_ok <= 1'b0;
    end else begin
      win <= {win[L-1:0], head};
      if (i_dval) begin
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
      end
      if (tail.dval && tail.eol) begin
        lv_ok <= 1'b0;
      end else if (tail.dval && (tail.data != DISP_INVALID)) begin
        lv    <= tail.data;
        lv_ok <= 1'b1;
      end
    end
  end

  // Registered output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dval   <= 1'b0;
      o_data   <= DISP_INVALID;
      o_filled <= 1'b0;
    end else begin
      o_dval   <= tail.dval;
      o_data   <= fill_data;
      o_filled <= fill_flag;
    end
  end

endmodule

// File: tb/tb_disparity_hole_fill.sv
// Scoreboard bench for disparity_hole_fill: directed test-plan streams plus random traffic,
// expected values from an array-based look-back/look-ahead model of the fill rules.
module tb_disparity_hole_fill;

  localparam int M    = 450;
  localparam int L    = 8;
  localparam int DB   = 6;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          dval;
  logic [DB-1:0] data;
  logic          o_dval;
  logic [DB-1:0] o_data;
  logic          o_filled;

  always #5 clk = ~clk;

  disparity_hole_fill #(.D(64), .M(M), .L(L)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_dval   (dval),
    .i_data   (data),
    .o_dval   (o_dval),
    .o_data   (o_data),
    .o_filled (o_filled)
  );

  // Stimulus per clock edge index.
  bit s_rst [MAXC];
  bit s_dv  [MAXC];
  int s_dat [MAXC];
  bit s_en  [MAXC];
  int ncyc = 0;

  // Model results per input edge.
  bit keep  [MAXC];
  int ep_a  [MAXC];
  int bt_a  [MAXC];
  bit e_ok  [MAXC];
  int e_dat [MAXC];
  bit e_fill[MAXC];

  typedef struct {
    int at_edge;
    int data;
    bit filled;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   passed   = 0;
  int   total    = 0;
  int   cur_edge = -1;
  bit   done     = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cur_edge);
  endtask

  task automatic put(input bit r, input bit v, input int d, input bit e);
    if (ncyc < MAXC) begin
      s_rst[ncyc] = r;
      s_dv[ncyc]  = v;
      s_dat[ncyc] = d;
      s_en[ncyc]  = e;
      ncyc++;
    end
  endtask

  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) put(1'b0, 1'b0, $urandom_range(63, 0), e);
  endtask

  task automatic reset_seq();
    put(1'b1, 1'b0, 0, 1'b1);
    put(1'b1, 1'b1, 5, 1'b1);
    idle(2, 1'b1);
  endtask

  task automatic build_stimulus();
    int zrun;
    bit cur_en;
    int d;
    // Initial reset, then 5,0,0,9.
    reset_seq();
    put(1'b0, 1'b1, 5, 1'b1); put(1'b0, 1'b1, 0, 1'b1);
    put(1'b0, 1'b1, 0, 1'b1); put(1'b0, 1'b1, 9, 1'b1);
    idle(12, 1'b1);
    // Row 1 ends in 12, row 2 starts with a hole followed by 7s.
    reset_seq();
    for (int i = 0; i < M - 1; i++) put(1'b0, 1'b1, $urandom_range(63, 1), 1'b1);
    put(1'b0, 1'b1, 12, 1'b1);
    put(1'b0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 10; i++) put(1'b0, 1'b1, 7, 1'b1);
    idle(12, 1'b1);
    // 3, ten holes, 6.
    reset_seq();
    put(1'b0, 1'b1, 3, 1'b1);
    for (int i = 0; i < 10; i++) put(1'b0, 1'b1, 0, 1'b1);
    put(1'b0, 1'b1, 6, 1'b1);
    idle(12, 1'b1);
    // Valid every other cycle: 4,_,0,_,2.
    reset_seq();
    put(1'b0, 1'b1, 4, 1'b1); put(1'b0, 1'b0, 33, 1'b1);
    put(1'b0, 1'b1, 0, 1'b1); put(1'b0, 1'b0, 17, 1'b1);
    put(1'b0, 1'b1, 2, 1'b1);
    idle(12, 1'b1);
    // Pass-through: 0,8,0 with i_en low at emission.
    reset_seq();
    put(1'b0, 1'b1, 0, 1'b0); put(1'b0, 1'b1, 8, 1'b0); put(1'b0, 1'b1, 0, 1'b0);
    idle(14, 1'b0);
    // Reset while five pixels are in flight; random traffic continues from col 0.
    reset_seq();
    for (int i = 0; i < 5; i++) put(1'b0, 1'b1, $urandom_range(63, 0), 1'b1);
    put(1'b1, 1'b1, 11, 1'b1);
    zrun   = 0;
    cur_en = 1'b1;
    for (int i = 0; i < 3400; i++) begin
      if ($urandom_range(99, 0) == 0) cur_en = ~cur_en;
      if (zrun == 0 && $urandom_range(19, 0) == 0) zrun = $urandom_range(16, 2);
      if (zrun > 0) begin
        d = 0;
        zrun--;
      end else begin
        d = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(63, 1);
      end
      put(($urandom_range(999, 0) == 0), ($urandom_range(9, 0) != 0), d, cur_en);
    end
    idle(2 * L + 4, 1'b1);
  endtask

  // Pixels belong to the same row when they share a reset epoch and beat/M.
  function automatic bit same_row(input int a, input int b);
    return (ep_a[a] == ep_a[b]) && ((bt_a[a] / M) == (bt_a[b] / M));
  endfunction

  task automatic build_model();
    int  ep;
    int  b;
    bit  drop;
    bit  lf;
    bit  rf;
    int  lvv;
    int  rvv;
    bit  en_at;
    ep = 0;
    b  = 0;
    for (int n = 0; n < ncyc; n++) begin
      keep[n] = 1'b0;
      ep_a[n] = -1;
      bt_a[n] = 0;
      if (s_rst[n]) begin
        ep++;
        b = 0;
      end else if (s_dv[n]) begin
        keep[n] = 1'b1;
        ep_a[n] = ep;
        bt_a[n] = b;
        b++;
      end
    end
    for (int n = 0; n < ncyc; n++) begin
      e_ok[n]   = 1'b0;
      e_dat[n]  = 0;
      e_fill[n] = 1'b0;
      if (keep[n]) begin
        drop = 1'b0;
        for (int m = n + 1; m <= n + L + 1 && m < ncyc; m++) if (s_rst[m]) drop = 1'b1;
        if (!drop) begin
          lf = 1'b0; lvv = 0;
          for (int m = n - 1; m >= 0; m--) begin
            if (s_rst[m] || lf) break;
            if (keep[m]) begin
              if (!same_row(m, n)) break;
              if (s_dat[m] != 0) begin lf = 1'b1; lvv = s_dat[m]; end
            end
          end
          rf = 1'b0; rvv = 0;
          for (int m = n + 1; m <= n + L && m < ncyc; m++) begin
            if (rf) break;
            if (keep[m]) begin
              if (!same_row(m, n)) break;
              if (s_dat[m] != 0) begin rf = 1'b1; rvv = s_dat[m]; end
            end
          end
          en_at    = (n + L + 1 < ncyc) ? s_en[n + L + 1] : 1'b1;
          e_ok[n]  = 1'b1;
          e_dat[n] = s_dat[n];
          if (en_at && s_dat[n] == 0) begin
`ifdef DHF_BG_FILL_EN
            if (lf && rf) begin e_dat[n] = (lvv < rvv) ? lvv : rvv; e_fill[n] = 1'b1; end
            else if (lf)  begin e_dat[n] = lvv; e_fill[n] = 1'b1; end
            else if (rf)  begin e_dat[n] = rvv; e_fill[n] = 1'b1; end
`else
            if (lf)       begin e_dat[n] = lvv; e_fill[n] = 1'b1; end
            else if (rf)  begin e_dat[n] = rvv; e_fill[n] = 1'b1; end
`endif
          end
        end
      end
    end
  endtask

  always @(posedge clk) cur_edge <= cur_edge + 1;

  // Monitor: reset-state checks and scoreboard comparison of every output beat.
  always @(negedge clk) begin
    if (cur_edge >= 0 && !done) begin
      if (cur_edge < ncyc && s_rst[cur_edge]) begin
        check("reset_o_dval", int'(o_dval), 0);
        check("reset_o_data", int'(o_data), 0);
        check("reset_o_filled", int'(o_filled), 0);
      end
      while (sb.size() > 0 && sb[0].at_edge < cur_edge) begin
        got = sb.pop_front();
        check("missing_output_edge", cur_edge, got.at_edge);
      end
      if (o_dval) begin
        if (sb.size() == 0) begin
          check("unexpected_o_dval", 1, 0);
        end else begin
          got = sb.pop_front();
          check("latency_edge", cur_edge, got.at_edge);
          check("o_data", int'(o_data), got.data);
          check("o_filled", int'(o_filled), int'(got.filled));
        end
      end
    end
  end

  // Driver: pushes the model's expectation as each pixel is issued.
  initial begin
    build_stimulus();
    build_model();
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) @(negedge clk);
      rst  = s_rst[n];
      dval = s_dv[n];
      data = DB'(s_dat[n]);
      en   = s_en[n];
      if (e_ok[n]) sb.push_back('{n + L + 1, e_dat[n], e_fill[n]});
    end
    @(negedge clk);
    rst  = 1'b0;
    dval = 1'b0;
    en   = 1'b1;
    repeat (L + 4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    @(posedge clk);
    done = 1'b1;
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/disparity_hole_fill.md
# disparity_hole_fill

Post-processing stage directly downstream of `stereo_match`. It consumes the raw disparity stream (`o_dval`/`o_data`), where pixels rejected by the left-right consistency check carry disparity code 0. It replaces each such hole with a disparity taken from the nearest valid neighbours on the same image row. Output is a fixed-latency, same-rate stream ready for the display/DMA writer.

## Interface
- `D`, 64, disparity range; `DBIT = $clog2(D)` (localparam)
- `M`, 450, pixels per row (valid beats per row)
- `L`, 8, lookahead depth in cycles; holes farther than L cycles from a right neighbour see no right candidate
- `i_clk`  in  1  clock; the only clock
- `i_rst`  in  1  reset, synchronous, active-high
- `i_en`  in  1  1 = fill holes; 0 = pass-through (data still delayed by L+1)
- `i_dval`  in  1  input disparity valid (gaps allowed)
- `i_data`  in  DBIT  input disparity; 0 = hole
- `o_dval`  out  1  output valid
- `o_data`  out  DBIT  filled disparity
- `o_filled`  out  1  qualifies o_dval; 1 when o_data was substituted for a hole

## Operation
- Window: (L+1)-slot shift register, advances every cycle (not gated by i_dval). Each slot holds {dval, data, eol}.
- Slot 0 is the head: newest input. Slot L is the tail: oldest, the pixel being emitted.
- Column counter `col`:
  - Counts i_dval beats 0..M-1 and wraps to 0.
  - A beat with col==M-1 is tagged eol=1.
- Left candidate `lv`:
  - Register with a valid flag.
  - Updated with the tail data when the tail is valid, nonzero and emitted.
  - Cleared (flag=0) after the tail with eol=1 is emitted, so holes never borrow across rows.
- Right candidate `rv`:
  - The valid, nonzero slot nearest the tail among slots L-1..0.
  - The search stops at the first slot whose tail-side path crosses an eol: slots beyond a pixel with eol=1 (including the tail itself when tail eol=1) are excluded.
  - Implemented as a combinational priority scan.
- Fill rule for a valid tail with data 0 and i_en=1:
  - Both candidates present: min(lv, rv) (background preference).
  - Only one present: that one.
  - Neither present: 0, with o_filled=0.
- Substitution sets o_filled=1.
- Valid nonzero tail pixels pass unchanged, o_filled=0.
- i_en=0: o_data = tail data, o_filled=0; `lv` and `col` keep updating.
- Arithmetic: unsigned DBIT-bit compare only, no widening.

## Timing
- Latency: exactly L+1 cycles from i_dval to o_dval for every pixel. Output gaps mirror input gaps.
- Throughput: one pixel per cycle, no backpressure.
- Reset: all slots dval=0, col=0, lv flag=0. o_dval=0, o_data=0, o_filled=0 during and after reset until the first pixel reaches the tail.
- Reset mid-row discards in-flight pixels. The next beat is treated as col 0.
- i_en change: sampled at emission time (tail), not at entry.
- Simultaneous eol-tail emission and lv update: clear wins.

## Configuration
- `DHF_BG_FILL_EN` defined: fill rule as above (min of left/right).
- Undefined: left-fill only. Use lv if present; else use rv (row start only); else 0.
- In the undefined build the min comparator is removed. Ports and latency are unchanged.

## Structure
- Shared package `stereo_pkg`:
  - DBIT derivation function.
  - Hole code constant `DISP_INVALID = 0`.
  - Slot struct {dval, data, eol}.
- One natural sub-module: `disp_nearest_valid`, the combinational eol-bounded priority scan returning {found, value} for the right candidate.
- Column counter, lv register and fill mux stay in the top.

## Test plan
- Continuous stream 5,0,0,9 (L=8, M=450, i_en=1): output 5,5,5,9 with o_filled 0,1,1,0. Each output appears 9 cycles after its input.
- Hole at col 0 of row 2 with row 1 ending in 12 and row 2 cols 1.. = 7: output 7, o_filled=1 (12 never used). With the macro undefined the result is the same.
- Stream 3,0,...,0 (10 holes), then 6: holes within 8 cycles of the 6 get min(3,6)=3. Holes further away get 3 (left only). Macro undefined: all holes get 3.
- Input with i_dval gaps (valid every other cycle) 4,_,0,_,2: output valid pattern identical, shifted by 9 cycles. The hole becomes 2 with the macro defined, 4 without.
- i_en=0 with stream 0,8,0: output 0,8,0, o_filled all 0, latency 9.
- Assert i_rst for one cycle while 5 pixels are in flight: o_dval=0 for the following 9 cycles. The next input is counted as col 0 (eol lands on its 450th beat).
